// File: rtl/higher_memory_arbiter.sv
// Round-robin 2:1 arbiter onto the shared higher-memory port; grant in 1 cycle, completion forwarded combinationally.
// One transaction in flight; a losing requester simply holds valid until its turn.
package memory_pkg;
  typedef enum logic [1:0] {
    MEM_LOAD  = 2'd0,
    MEM_STORE = 2'd1,
    MEM_FENCE = 2'd2
  } memory_operation_e;
endpackage

module higher_memory_arbiter
  import memory_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [XLEN-1:0]   s0_req_address,
  input  memory_operation_e s0_req_operation,
  input  logic [XLEN-1:0]   s0_req_store_word,
  input  logic              s0_req_valid,
  output logic [XLEN-1:0]   s0_req_loaded_word,
  output logic              s0_req_fulfilled,

  input  logic [XLEN-1:0]   s1_req_address,
  input  memory_operation_e s1_req_operation,
  input  logic [XLEN-1:0]   s1_req_store_word,
  input  logic              s1_req_valid,
  output logic [XLEN-1:0]   s1_req_loaded_word,
  output logic              s1_req_fulfilled,

  output logic [XLEN-1:0]   m_req_address,
  output memory_operation_e m_req_operation,
  output logic [XLEN-1:0]   m_req_store_word,
  output logic              m_req_valid,
  input  logic [XLEN-1:0]   m_req_loaded_word,
  input  logic              m_req_fulfilled
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   prio_q, prio_d;
  logic   cand0, cand1, sel;
  logic   grant, clear;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    owner_d            = owner_q;
    prio_d             = prio_q;
    grant              = 1'b0;
    clear              = 1'b0;
    s0_req_fulfilled   = 1'b0;
    s0_req_loaded_word = '0;
    s1_req_fulfilled   = 1'b0;
    s1_req_loaded_word = '0;

    // The just-finished owner may still hold valid during DRAIN; ignore it there.
    cand0 = s0_req_valid && !(state_q == ST_DRAIN && owner_q == 1'b0);
    cand1 = s1_req_valid && !(state_q == ST_DRAIN && owner_q == 1'b1);
    sel   = (cand0 && cand1) ? prio_q : cand1;

    case (state_q)
      ST_IDLE, ST_DRAIN: begin
        if (cand0 || cand1) begin
          grant   = 1'b1;
          owner_d = sel;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (m_req_fulfilled) begin
          clear   = 1'b1;
          prio_d  = ~owner_q;
          state_d = ST_DRAIN;
          if (owner_q) begin
            s1_req_fulfilled   = 1'b1;
            s1_req_loaded_word = m_req_loaded_word;
          end else begin
            s0_req_fulfilled   = 1'b1;
            s0_req_loaded_word = m_req_loaded_word;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_req_valid      <= 1'b0;
      m_req_address    <= '0;
      m_req_store_word <= '0;
      m_req_operation  <= MEM_LOAD;
    end else if (grant) begin
      m_req_valid      <= 1'b1;
      m_req_address    <= sel ? s1_req_address    : s0_req_address;
      m_req_store_word <= sel ? s1_req_store_word : s0_req_store_word;
      m_req_operation  <= sel ? s1_req_operation  : s0_req_operation;
    end else if (clear) begin
      m_req_valid      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_higher_memory_arbiter.sv
// Directed bench for higher_memory_arbiter with hand-computed expectations.
module tb_higher_memory_arbiter;
  import memory_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       s0_req_address, s0_req_store_word, s0_req_loaded_word;
  memory_operation_e s0_req_operation;
  logic              s0_req_valid, s0_req_fulfilled;
  logic [31:0]       s1_req_address, s1_req_store_word, s1_req_loaded_word;
  memory_operation_e s1_req_operation;
  logic              s1_req_valid, s1_req_fulfilled;
  logic [31:0]       m_req_address, m_req_store_word, m_req_loaded_word;
  memory_operation_e m_req_operation;
  logic              m_req_valid, m_req_fulfilled;

  int checks = 0;
  int errors = 0;

  higher_memory_arbiter #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .s0_req_address(s0_req_address), .s0_req_operation(s0_req_operation),
    .s0_req_store_word(s0_req_store_word), .s0_req_valid(s0_req_valid),
    .s0_req_loaded_word(s0_req_loaded_word), .s0_req_fulfilled(s0_req_fulfilled),
    .s1_req_address(s1_req_address), .s1_req_operation(s1_req_operation),
    .s1_req_store_word(s1_req_store_word), .s1_req_valid(s1_req_valid),
    .s1_req_loaded_word(s1_req_loaded_word), .s1_req_fulfilled(s1_req_fulfilled),
    .m_req_address(m_req_address), .m_req_operation(m_req_operation),
    .m_req_store_word(m_req_store_word), .m_req_valid(m_req_valid),
    .m_req_loaded_word(m_req_loaded_word), .m_req_fulfilled(m_req_fulfilled)
  );

  always #5 clk = ~clk;

  // An owner must keep valid up while memory is working on its request.
  always @(negedge clk) begin
    if (reset === 1'b0 && m_req_valid === 1'b1 && !s0_req_valid && !s1_req_valid) begin
      errors++;
      $error("FAIL protocol observed=m_req_valid_without_requester expected=requester_valid");
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic v, input logic [31:0] a,
                       input memory_operation_e op, input logic [31:0] d);
    if (p == 0) begin
      s0_req_valid = v; s0_req_address = a; s0_req_operation = op; s0_req_store_word = d;
    end else begin
      s1_req_valid = v; s1_req_address = a; s1_req_operation = op; s1_req_store_word = d;
    end
  endtask

  function automatic logic [31:0] c_addr(input int p, input int n);
    return (p == 1 ? 32'h0000_8000 : 32'h0000_4000) + 32'(n) * 32'd4;
  endfunction

  function automatic logic [31:0] c_data(input int p, input int n);
    return (p == 1 ? 32'hA5A5_0001 : 32'h5A5A_0001) + 32'(n);
  endfunction

  function automatic memory_operation_e c_op(input int p);
    return (p == 1) ? MEM_STORE : MEM_LOAD;
  endfunction

  initial begin
    reset = 1'b1;
    m_req_fulfilled = 1'b0;
    m_req_loaded_word = '0;
    drive(0, 1'b0, '0, MEM_LOAD, '0);
    drive(1, 1'b0, '0, MEM_LOAD, '0);

    // cycles 0,1: reset
    step();
    step();
    #1;
    chk("rst_m_valid", 32'(m_req_valid), 32'd0);
    chk("rst_m_addr", m_req_address, 32'd0);
    chk("rst_m_store", m_req_store_word, 32'd0);
    chk("rst_m_op", 32'(m_req_operation), 32'd0);
    chk("rst_s0_f", 32'(s0_req_fulfilled), 32'd0);
    chk("rst_s1_loaded", s1_req_loaded_word, 32'd0);

    // single load on port 0, memory latency 3
    step();                                   // cycle 2
    reset = 1'b0;
    drive(0, 1'b1, 32'h0000_1000, MEM_LOAD, 32'd0);
    #1;
    chk("t1_no_comb_grant", 32'(m_req_valid), 32'd0);
    step();                                   // cycle 3
    chk("t1_m_valid", 32'(m_req_valid), 32'd1);
    chk("t1_m_addr", m_req_address, 32'h0000_1000);
    chk("t1_m_op", 32'(m_req_operation), 32'(MEM_LOAD));
    step();                                   // cycle 4
    chk("t1_hold_s0_f", 32'(s0_req_fulfilled), 32'd0);
    step();                                   // cycle 5
    step();                                   // cycle 6
    m_req_fulfilled = 1'b1;
    m_req_loaded_word = 32'hDEAD_BEEF;
    #1;
    chk("t1_s0_f", 32'(s0_req_fulfilled), 32'd1);
    chk("t1_s0_loaded", s0_req_loaded_word, 32'hDEAD_BEEF);
    chk("t1_s1_f", 32'(s1_req_fulfilled), 32'd0);
    chk("t1_s1_loaded", s1_req_loaded_word, 32'd0);
    step();                                   // cycle 7, DRAIN
    m_req_fulfilled = 1'b0;
    drive(0, 1'b0, 32'h0000_1000, MEM_LOAD, 32'd0);
    #1;
    chk("t1_drain_m_valid", 32'(m_req_valid), 32'd0);
    step();
    chk("t1_idle_m_valid", 32'(m_req_valid), 32'd0);

    // simultaneous requests right after reset: port 0 first, port 1 at F+2
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(0, 1'b1, 32'h0000_2000, MEM_LOAD, 32'd0);
    drive(1, 1'b1, 32'h0000_3000, MEM_STORE, 32'h0000_1234);
    step();
    chk("t2_first_addr", m_req_address, 32'h0000_2000);
    step();                                   // F
    m_req_fulfilled = 1'b1;
    m_req_loaded_word = 32'h1111_1111;
    #1;
    chk("t2_s0_f", 32'(s0_req_fulfilled), 32'd1);
    chk("t2_s1_f_idle", 32'(s1_req_fulfilled), 32'd0);
    step();                                   // F+1
    m_req_fulfilled = 1'b0;
    drive(0, 1'b0, 32'h0000_2000, MEM_LOAD, 32'd0);
    #1;
    chk("t2_drain_m_valid", 32'(m_req_valid), 32'd0);
    step();                                   // F+2
    chk("t2_second_valid", 32'(m_req_valid), 32'd1);
    chk("t2_second_addr", m_req_address, 32'h0000_3000);
    chk("t2_second_op", 32'(m_req_operation), 32'(MEM_STORE));
    chk("t2_second_store", m_req_store_word, 32'h0000_1234);
    step();
    m_req_fulfilled = 1'b1;
    m_req_loaded_word = 32'h2222_2222;
    #1;
    chk("t2_s1_f", 32'(s1_req_fulfilled), 32'd1);
    chk("t2_s1_loaded", s1_req_loaded_word, 32'h2222_2222);
    chk("t2_s0_f_other", 32'(s0_req_fulfilled), 32'd0);
    step();
    m_req_fulfilled = 1'b0;
    drive(1, 1'b0, 32'h0000_3000, MEM_STORE, 32'h0000_1234);
    step();

    // continuous contention, memory latency 1; prio now points at port 0
    drive(0, 1'b1, c_addr(0, 0), c_op(0), c_data(0, 0));
    drive(1, 1'b1, c_addr(1, 0), c_op(1), c_data(1, 0));
    for (int i = 0; i < 6; i++) begin
      int p;
      int n;
      p = i % 2;
      n = i / 2;
      for (int w = 0; w < 10 && !m_req_valid; w++) step();
      chk($sformatf("t3_grant%0d_valid", i), 32'(m_req_valid), 32'd1);
      chk($sformatf("t3_grant%0d_addr", i), m_req_address, c_addr(p, n));
      chk($sformatf("t3_grant%0d_store", i), m_req_store_word, c_data(p, n));
      chk($sformatf("t3_grant%0d_op", i), 32'(m_req_operation), 32'(c_op(p)));
      step();
      m_req_fulfilled = 1'b1;
      m_req_loaded_word = 32'hC0DE_0000 + 32'(i);
      #1;
      chk($sformatf("t3_done%0d_owner_f", i),
          32'(p == 0 ? s0_req_fulfilled : s1_req_fulfilled), 32'd1);
      chk($sformatf("t3_done%0d_other_f", i),
          32'(p == 0 ? s1_req_fulfilled : s0_req_fulfilled), 32'd0);
      step();
      m_req_fulfilled = 1'b0;
      drive(p, 1'b0, c_addr(p, n), c_op(p), c_data(p, n));
      step();
      if (i + 2 < 6) drive(p, 1'b1, c_addr(p, n + 1), c_op(p), c_data(p, n + 1));
    end
    step();
    chk("t3_end_idle", 32'(m_req_valid), 32'd0);

    // stale valid held through DRAIN must not start a second request
    drive(0, 1'b1, 32'h0000_6000, MEM_LOAD, 32'd0);
    step();
    chk("t4_first_addr", m_req_address, 32'h0000_6000);
    step();                                   // F
    m_req_fulfilled = 1'b1;
    m_req_loaded_word = 32'h6666_6666;
    #1;
    chk("t4_s0_f", 32'(s0_req_fulfilled), 32'd1);
    step();                                   // F+1, s0 still valid
    m_req_fulfilled = 1'b0;
    #1;
    chk("t4_drain_no_req", 32'(m_req_valid), 32'd0);
    step();                                   // F+2, real new request
    drive(0, 1'b1, 32'h0000_7000, MEM_LOAD, 32'd0);
    #1;
    chk("t4_f2_no_req", 32'(m_req_valid), 32'd0);
    step();                                   // F+3
    chk("t4_f3_valid", 32'(m_req_valid), 32'd1);
    chk("t4_f3_addr", m_req_address, 32'h0000_7000);

    // reset while BUSY
    reset = 1'b1;
    drive(0, 1'b0, 32'd0, MEM_LOAD, 32'd0);
    step();
    chk("t5_m_valid", 32'(m_req_valid), 32'd0);
    chk("t5_m_addr", m_req_address, 32'd0);
    chk("t5_m_op", 32'(m_req_operation), 32'd0);
    reset = 1'b0;
    m_req_fulfilled = 1'b1;
    m_req_loaded_word = 32'h0BAD_0BAD;
    #1;
    chk("t5_stray_s0_f", 32'(s0_req_fulfilled), 32'd0);
    chk("t5_stray_s1_f", 32'(s1_req_fulfilled), 32'd0);
    step();
    m_req_fulfilled = 1'b0;

    // spurious memory fulfilled while IDLE
    step();
    m_req_fulfilled = 1'b1;
    m_req_loaded_word = 32'hFFFF_0000;
    #1;
    chk("t6_s0_f", 32'(s0_req_fulfilled), 32'd0);
    chk("t6_s0_loaded", s0_req_loaded_word, 32'd0);
    chk("t6_s1_loaded", s1_req_loaded_word, 32'd0);
    step();
    m_req_fulfilled = 1'b0;
    #1;
    chk("t6_m_valid", 32'(m_req_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/higher_memory_arbiter.md
# higher_memory_arbiter

Two-to-one arbiter between two L1 caches' higher-memory request ports and the single shared higher-memory port. Port 0 is normally the instruction cache and port 1 the data cache.
- Each requester and the memory side use the same valid/fulfilled handshake and signal set as the cache's higher-memory interface: address, `memory_operation_e` operation, store word, loaded word.
- Requests are granted round-robin, one outstanding transaction at a time, with registered request outputs toward memory.

## Interface
- `XLEN`, default 32: address and data width.
- `clk` input 1: single clock, all state updates on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `s0_req_address` input XLEN: requester 0 address.
- `s0_req_operation` input `memory_operation_e`: requester 0 operation.
- `s0_req_store_word` input XLEN: requester 0 store data.
- `s0_req_valid` input 1: requester 0 request pending.
- `s0_req_loaded_word` output XLEN: load data returned to requester 0.
- `s0_req_fulfilled` output 1: one-cycle completion pulse to requester 0.
- `s1_req_*`: same six signals as `s0_req_*`, for requester 1.
- `m_req_address` output XLEN: address to higher memory.
- `m_req_operation` output `memory_operation_e`: operation to higher memory.
- `m_req_store_word` output XLEN: store data to higher memory.
- `m_req_valid` output 1: request to higher memory.
- `m_req_loaded_word` input XLEN: load data from higher memory.
- `m_req_fulfilled` input 1: completion from higher memory.

## Operation
Handshake rules, all ports:
- A requester raises valid with stable fields and holds both until it sees fulfilled high for one cycle.
- The requester deasserts valid on the following cycle.

State machine, with states IDLE, BUSY and DRAIN:
- **IDLE:** if any `sN_req_valid` is high, select the owner:
  - If only one requester is valid, it is selected.
  - If both are valid, select the requester indicated by priority pointer `prio`.
  - Register the owner's address, operation and store word into the `m_req_*` registers.
  - Set `m_req_valid` = 1.
  - Move to BUSY.
- **BUSY:** `m_req_*` are held constant.
  - On `m_req_fulfilled` = 1, combinationally drive owner `sN_req_fulfilled` = 1 and `sN_req_loaded_word` = `m_req_loaded_word` in the same cycle.
  - Clear `m_req_valid` at the next edge.
  - Set `prio` to the non-owner.
  - Move to DRAIN.
- **DRAIN:** lasts exactly one cycle.
  - The finished owner's valid is masked, because it may still be high in this cycle.
  - If the other requester is valid, grant it exactly as in IDLE and go to BUSY; otherwise go to IDLE.

Outputs toward the non-owner, and toward the owner when not fulfilling:
- `sN_req_fulfilled` = 0.
- `sN_req_loaded_word` = 0.

Protocol violations:
- `m_req_fulfilled` arriving in IDLE or DRAIN is ignored; nothing is forwarded.
- An owner dropping valid while in BUSY does not abort the transaction. It completes and its fulfilled pulse is still issued. This is a protocol violation flagged by a bench assertion.

Operations pass through unmodified.

Reset, also when asserted mid-transaction:
- State goes to IDLE and `prio` to 0.
- `m_req_valid` = 0, `m_req_address` = 0, `m_req_store_word` = 0, `m_req_operation` = enum value 0.
- All `sN_req_fulfilled` = 0 and `sN_req_loaded_word` = 0.
- An in-flight memory transaction is abandoned. Memory is reset in the same cycle.

## Timing
- Grant latency: requester valid first seen in IDLE at cycle T gives `m_req_valid` = 1 at T+1.
- Completion: fulfilled passes memory→requester with zero added latency (combinational).
- Back-to-back: with memory fulfilled at cycle F:
  - DRAIN occurs at F+1.
  - The other requester, if waiting, sees `m_req_valid` at F+2.
  - The same requester re-requesting is first considered at F+2 (IDLE) and is issued at F+3.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1.
- No combinational path from `sN_req_*` inputs to `m_req_*` outputs.
- The only combinational paths are `m_req_fulfilled`/`m_req_loaded_word` to `sN_*`.

## Test plan
- **Single load, port 0:**
  - Stimulus: `s0_req_valid` at cycle 2 with address 0x0000_1000; memory fulfills 3 cycles after `m_req_valid`, loaded word 0xDEAD_BEEF.
  - Response: `m_req_valid` at cycle 3 with address 0x1000; `s0_req_fulfilled` pulses at cycle 6 with 0xDEAD_BEEF; `s1_req_fulfilled` stays 0.
- **Simultaneous requests after reset:**
  - Stimulus: both requesters valid in the same cycle.
  - Response: port 0 is granted first. Port 1's address appears on `m_req_address` exactly 2 cycles after port 0's fulfilled, i.e. at F+2.
- **Continuous contention, 6 transactions, memory latency 1:**
  - Response: grant order is 0,1,0,1,0,1. Every store word reaches `m_req_store_word` unaltered, e.g. s1 0xA5A5_0001.
- **Stale-valid masking:**
  - Stimulus: s0 holds valid for one cycle after its fulfilled; s1 is idle.
  - Response: no second memory request in DRAIN. s0's next real request is issued at F+3.
- **Reset mid-BUSY:**
  - Stimulus: assert reset while `m_req_valid` = 1.
  - Response: the next cycle has all outputs at reset values and state IDLE. A stray `m_req_fulfilled` afterwards produces no `sN_req_fulfilled`.
- **Spurious memory fulfilled in IDLE:**
  - Response: no `sN_req_fulfilled` pulse and loaded words stay 0.
